// File: rtl/instr_dcd_pkg.sv
// Shared definitions for the SPI command decoder: state encoding and command byte layout.
package instr_dcd_pkg;

    typedef enum logic [1:0] {
        S_CMD   = 2'd0,
        S_DATA  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam int unsigned CMD_RW_BIT    = 7;
    localparam int unsigned CMD_BURST_BIT = 6;
    localparam int unsigned CMD_ADDR_MSB  = 5;

endpackage

// File: rtl/instr_dcd_addr_ctr.sv
// Loadable wrapping address counter plus burst byte counter with a last-byte flag.
module instr_dcd_addr_ctr #(
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              addr_inc,
    input  logic              cnt_clr,
    input  logic              cnt_inc,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [ADDR_W-1:0] next_addr,
    output logic              last
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt_q;

    // Address register: load from the command byte, otherwise step with natural wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
        end else if (load) begin
            addr_q <= load_addr;
        end else if (addr_inc) begin
            addr_q <= next_addr;
        end
    end

    // Data byte counter for the current frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (cnt_inc) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cur_addr  = addr_q;
    assign next_addr = addr_q + ADDR_W'(1);
    // High while the byte being accepted is the final one allowed in the frame.
    assign last      = (cnt_q == CNT_W'(MAX_BURST - 1));

endmodule

// File: rtl/instr_dcd_burst.sv
// SPI command decoder with auto-increment bursts, bounded burst length and frame abort.
module instr_dcd_burst
    import instr_dcd_pkg::*;
#(
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned MAX_BURST = 16,
    parameter bit          BURST_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_sync,
    input  logic [7:0]        data_in,
    input  logic              frame_end,
    output logic [7:0]        data_out,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    input  logic [7:0]        data_read,
    output logic [7:0]        data_write,
    output logic              busy,
    output logic              burst_ovf
);

    state_t            state_q, state_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_write_q, data_write_d;
    logic [7:0]        data_out_q, data_out_d;
    logic              op_wr_q, op_wr_d;
    logic              burst_q, burst_d;
    logic              ovf_q, ovf_d;

    logic              ctr_load, ctr_addr_inc, ctr_cnt_clr, ctr_cnt_inc;
    logic [ADDR_W-1:0] cur_addr, next_addr;
    logic              last;
    logic [CMD_ADDR_MSB:0] cmd_addr;

    assign cmd_addr = data_in[CMD_ADDR_MSB:0];

    instr_dcd_addr_ctr #(
        .ADDR_W    (ADDR_W),
        .MAX_BURST (MAX_BURST)
    ) u_addr_ctr (
        .clk       (clk),
        .rst       (rst),
        .load      (ctr_load),
        .load_addr (cmd_addr[ADDR_W-1:0]),
        .addr_inc  (ctr_addr_inc),
        .cnt_clr   (ctr_cnt_clr),
        .cnt_inc   (ctr_cnt_inc),
        .cur_addr  (cur_addr),
        .next_addr (next_addr),
        .last      (last)
    );

    // Next-state and strobe decode; frame_end overrides any byte in the same cycle.
    always_comb begin
        state_d      = state_q;
        read_d       = 1'b0;
        write_d      = 1'b0;
        addr_d       = addr_q;
        data_write_d = data_write_q;
        // A read strobe in flight always captures its register data, even across frame_end.
        data_out_d   = read_q ? data_read : data_out_q;
        op_wr_d      = op_wr_q;
        burst_d      = burst_q;
        ovf_d        = ovf_q;
        ctr_load     = 1'b0;
        ctr_addr_inc = 1'b0;
        ctr_cnt_clr  = 1'b0;
        ctr_cnt_inc  = 1'b0;

        if (frame_end) begin
            state_d     = S_CMD;
            ctr_cnt_clr = 1'b1;
        end else if (byte_sync) begin
            unique case (state_q)
                S_CMD: begin
                    op_wr_d     = data_in[CMD_RW_BIT];
                    burst_d     = BURST_EN && data_in[CMD_BURST_BIT];
                    ctr_load    = 1'b1;
                    ctr_cnt_clr = 1'b1;
                    ovf_d       = 1'b0;
                    state_d     = S_DATA;
                    if (data_in[CMD_RW_BIT]) begin
                        data_out_d = 8'h00;
                    end else begin
                        read_d = 1'b1;
                        addr_d = cmd_addr[ADDR_W-1:0];
                    end
                end
                S_DATA: begin
                    ctr_cnt_inc = 1'b1;
                    if (op_wr_q) begin
                        write_d      = 1'b1;
                        addr_d       = cur_addr;
                        data_write_d = data_in;
                        ctr_addr_inc = burst_q;
                    end else if (burst_q && !last) begin
                        // Prefetch the next register so its data is ready for the next byte.
                        read_d       = 1'b1;
                        addr_d       = next_addr;
                        ctr_addr_inc = 1'b1;
                    end
                    if (!burst_q) begin
                        state_d = S_CMD;
                    end else if (last) begin
                        state_d = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    ovf_d = 1'b1;
                end
                default: begin
                    state_d = S_CMD;
                end
            endcase
        end
    end

    // State, strobe and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_CMD;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            data_write_q <= 8'h00;
            data_out_q   <= 8'h00;
            op_wr_q      <= 1'b0;
            burst_q      <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            read_q       <= read_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            data_write_q <= data_write_d;
            data_out_q   <= data_out_d;
            op_wr_q      <= op_wr_d;
            burst_q      <= burst_d;
            ovf_q        <= ovf_d;
        end
    end

    assign read       = read_q;
    assign write      = write_q;
    assign addr       = addr_q;
    assign data_write = data_write_q;
    assign data_out   = data_out_q;
    assign busy       = (state_q != S_CMD);
    assign burst_ovf  = ovf_q;

endmodule

// File: tb/tb_instr_dcd_burst.sv
// Directed bench for instr_dcd_burst with a strobe scoreboard and register-file model.
module tb_instr_dcd_burst;

    localparam int unsigned ADDR_W    = 6;
    localparam int unsigned MAX_BURST = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              byte_sync;
    logic [7:0]        data_in;
    logic              frame_end;
    logic [7:0]        data_out;
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data_read;
    logic [7:0]        data_write;
    logic              busy;
    logic              burst_ovf;

    typedef struct packed {
        logic       wr;
        logic [5:0] a;
        logic [7:0] d;
    } txn_t;

    txn_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   sync_cyc = -100;
    logic dout_pend = 1'b0;
    logic [7:0] dout_exp = 8'h00;

    always #5 clk = ~clk;

    // Register file model: contents are a fixed function of the address.
    function automatic logic [7:0] reg_val(input logic [5:0] a);
        return {2'b00, a} ^ 8'h7D;
    endfunction

    assign data_read = read ? reg_val(addr) : 8'h00;

    instr_dcd_burst #(
        .ADDR_W    (ADDR_W),
        .MAX_BURST (MAX_BURST),
        .BURST_EN  (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_sync  (byte_sync),
        .data_in    (data_in),
        .frame_end  (frame_end),
        .data_out   (data_out),
        .read       (read),
        .write      (write),
        .addr       (addr),
        .data_read  (data_read),
        .data_write (data_write),
        .busy       (busy),
        .burst_ovf  (burst_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic wr, input logic [5:0] a, input logic [7:0] d);
        txn_t t;
        t.wr = wr;
        t.a  = a;
        t.d  = d;
        exp_q.push_back(t);
    endtask

    task automatic send(input logic [7:0] b, input logic fe);
        @(posedge clk);
        #1;
        byte_sync = 1'b1;
        frame_end = fe;
        data_in   = b;
        @(posedge clk);
        #1;
        byte_sync = 1'b0;
        frame_end = 1'b0;
        repeat (9) @(posedge clk);
        #1;
    endtask

    task automatic end_frame();
        @(posedge clk);
        #1;
        frame_end = 1'b1;
        @(posedge clk);
        #1;
        frame_end = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_sb_empty"}, exp_q.size(), 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic zero_chk(input string tag);
        chk({tag, "_data_out"}, data_out, 0);
        chk({tag, "_read"}, read, 0);
        chk({tag, "_write"}, write, 0);
        chk({tag, "_addr"}, addr, 0);
        chk({tag, "_data_write"}, data_write, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_burst_ovf"}, burst_ovf, 0);
    endtask

    // Cycle stamp of the last accepted byte, used to check strobe latency.
    always @(posedge clk) begin
        cyc++;
        if (byte_sync && !frame_end) sync_cyc = cyc;
    end

    // Strobe monitor: pops the scoreboard on each strobe and checks read data one cycle later.
    always @(negedge clk) begin
        txn_t e;
        if (!rst) begin
            if (dout_pend) begin
                chk("data_out_after_read", data_out, dout_exp);
                dout_pend = 1'b0;
            end
            if (read || write) begin
                chk("rd_wr_excl", read & write, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", {read, write}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_kind", write, e.wr);
                    chk("strobe_addr", addr, e.a);
                    chk("strobe_latency", cyc - sync_cyc, 0);
                    if (e.wr) begin
                        chk("data_write", data_write, e.d);
                    end else begin
                        dout_pend = 1'b1;
                        dout_exp  = reg_val(e.a);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        byte_sync = 1'b0;
        frame_end = 1'b0;
        data_in   = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        zero_chk("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single write
        push(1'b1, 6'd5, 8'h3C);
        send(8'h85, 1'b0);
        chk("wr_busy", busy, 1);
        send(8'h3C, 1'b0);
        idle_chk("single_wr");

        // Single read, dummy data byte must not strobe
        push(1'b0, 6'd10, 8'h00);
        send(8'h0A, 1'b0);
        chk("rd_busy", busy, 1);
        chk("rd_data_out", data_out, 8'h77);
        send(8'h55, 1'b0);
        idle_chk("single_rd");
        chk("rd_data_out_hold", data_out, 8'h77);

        // Burst write wrapping past the top address
        push(1'b1, 6'd62, 8'h11);
        push(1'b1, 6'd63, 8'h22);
        push(1'b1, 6'd0,  8'h33);
        send(8'hFE, 1'b0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        chk("wrap_addr_hold", addr, 0);
        end_frame();
        idle_chk("wrap");

        // Burst limit: only MAX_BURST writes, then overflow flag
        for (int i = 0; i < 4; i++) push(1'b1, 6'(i), 8'(8'hA0 + i));
        send(8'hC0, 1'b0);
        for (int i = 0; i < 4; i++) send(8'(8'hA0 + i), 1'b0);
        chk("limit_ovf_at_max", burst_ovf, 0);
        chk("limit_drain_busy", busy, 1);
        send(8'hA4, 1'b0);
        chk("limit_ovf_set", burst_ovf, 1);
        send(8'hA5, 1'b0);
        end_frame();
        chk("limit_ovf_sticky", burst_ovf, 1);
        idle_chk("limit");
        push(1'b0, 6'd7, 8'h00);
        send(8'h07, 1'b0);
        chk("limit_ovf_cleared", burst_ovf, 0);
        end_frame();
        idle_chk("limit_next");

        // Burst read: prefetch stops at the limit
        for (int i = 16; i < 20; i++) push(1'b0, 6'(i), 8'h00);
        send(8'h50, 1'b0);
        for (int i = 0; i < 4; i++) send(8'h00, 1'b0);
        chk("brd_drain_busy", busy, 1);
        send(8'h00, 1'b0);
        chk("brd_ovf", burst_ovf, 1);
        end_frame();
        idle_chk("burst_rd");

        // Abort: frame_end with byte_sync discards the byte
        push(1'b1, 6'd8, 8'h5A);
        send(8'hC8, 1'b0);
        send(8'h5A, 1'b0);
        send(8'h6B, 1'b1);
        idle_chk("abort");
        push(1'b0, 6'd2, 8'h00);
        send(8'h02, 1'b0);
        chk("abort_fresh_rd", data_out, 8'h7F);
        chk("abort_fresh_busy", busy, 1);
        end_frame();
        idle_chk("abort_next");

        // Reset mid-burst with a byte in flight
        push(1'b1, 6'd4, 8'h99);
        send(8'hC4, 1'b0);
        send(8'h99, 1'b0);
        @(posedge clk);
        #1;
        byte_sync = 1'b1;
        data_in   = 8'hEE;
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        byte_sync = 1'b0;
        zero_chk("mid_rst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle_chk("mid_rst_release");
        push(1'b0, 6'd3, 8'h00);
        send(8'h03, 1'b0);
        chk("post_rst_rd", data_out, 8'h7E);
        end_frame();
        idle_chk("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
